vid_timing_gen: RTL and testbench

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

---
 rtl/vtg_pkg.sv | 25 ++
 rtl/vtg_axis_counter.sv | 60 ++++++
 rtl/vid_timing_gen.sv | 131 +++++++++++++
 tb/tb_vid_timing_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// Shared constants for the video timing generator: default 720x480 timing,
// the colour-bar table and the counter-width helper.
package vtg_pkg;

    localparam int unsigned VTG_H_ACTIVE = 720;
    localparam int unsigned VTG_H_FP     = 16;
    localparam int unsigned VTG_H_SYNC   = 62;
    localparam int unsigned VTG_H_BP     = 60;
    localparam int unsigned VTG_V_ACTIVE = 480;
    localparam int unsigned VTG_V_FP     = 9;
    localparam int unsigned VTG_V_SYNC   = 6;
    localparam int unsigned VTG_V_BP     = 30;
    localparam int unsigned VTG_DATA_W   = 16;

    // RGB565 bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [VTG_DATA_W-1:0] VTG_BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    function automatic int unsigned vtg_cnt_w(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One timing axis: position counter plus registered sync level, with the
// next count and next active flag exposed so the top can register its decodes.
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int unsigned ACTIVE = VTG_H_ACTIVE,
    parameter int unsigned FP     = VTG_H_FP,
    parameter int unsigned SYNC   = VTG_H_SYNC,
    parameter int unsigned BP     = VTG_H_BP,
    parameter logic        POL    = 1'b0,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned W     = vtg_cnt_w(TOTAL)
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         i_step,
    input  logic         i_clear,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_sync,
    output logic         o_next_active
);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam int unsigned  SYNC_LO = ACTIVE + FP;
    localparam int unsigned  SYNC_HI = ACTIVE + FP + SYNC;

    logic [W-1:0] r_count;
    logic         r_sync;
    logic [31:0]  w_next32;
    logic         w_next_sync;

    // Clear outranks the natural wrap so a restart lands exactly on zero.
    always_comb begin
        o_next = r_count;
        if (i_clear) begin
            o_next = '0;
        end else if (i_step) begin
            o_next = (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign w_next32      = 32'(o_next);
    assign o_next_active = (w_next32 < ACTIVE);
    assign w_next_sync   = (w_next32 >= SYNC_LO) && (w_next32 < SYNC_HI);

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_count <= LAST;
            r_sync  <= ~POL;
        end else if (i_step || i_clear) begin
            r_count <= o_next;
            r_sync  <= w_next_sync ? POL : ~POL;
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator: pixel-clock divider, H/V counters and sync/DE decode.
// Optional colour-bar pattern on pix_data when VTG_TESTPAT_EN is defined.
module vid_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VTG_H_ACTIVE,
    parameter int unsigned H_FP     = VTG_H_FP,
    parameter int unsigned H_SYNC   = VTG_H_SYNC,
    parameter int unsigned H_BP     = VTG_H_BP,
    parameter int unsigned V_ACTIVE = VTG_V_ACTIVE,
    parameter int unsigned V_FP     = VTG_V_FP,
    parameter int unsigned V_SYNC   = VTG_V_SYNC,
    parameter int unsigned V_BP     = VTG_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned DATA_W   = VTG_DATA_W,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW      = vtg_cnt_w(H_TOTAL),
    localparam int unsigned YW      = vtg_cnt_w(V_TOTAL)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              enable,
    input  logic              sync_restart,
    output logic              vCLK,
    output logic              Hs,
    output logic              Vs,
    output logic              De,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              frame_start,
    output logic [DATA_W-1:0] pix_data
);

    localparam int unsigned    DW       = vtg_cnt_w(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam int unsigned    DIV_HALF = CLK_DIV / 2;
    localparam logic [XW-1:0]  H_LAST   = XW'(H_TOTAL - 1);

    logic [DW-1:0] r_div;
    logic          r_vclk;
    logic          r_de;
    logic          r_fs;
    logic          w_tick;
    logic          w_restart;
    logic          w_h_nact;
    logic          w_v_nact;
    logic [XW-1:0] w_h_next;
    logic [YW-1:0] w_v_next;

    assign w_tick    = enable && (r_div == DIV_LAST);
    assign w_restart = w_tick && sync_restart;

    vtg_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
    ) u_h (
        .clk           (clk),
        .Reset         (Reset),
        .i_step        (w_tick),
        .i_clear       (w_restart),
        .o_count       (pix_x),
        .o_next        (w_h_next),
        .o_sync        (Hs),
        .o_next_active (w_h_nact)
    );

    vtg_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
    ) u_v (
        .clk           (clk),
        .Reset         (Reset),
        .i_step        (w_tick && (pix_x == H_LAST)),
        .i_clear       (w_restart),
        .o_count       (pix_y),
        .o_next        (w_v_next),
        .o_sync        (Vs),
        .o_next_active (w_v_nact)
    );

    // vCLK reflects the pre-edge divider count, so it toggles every clk at CLK_DIV=2.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_div  <= '0;
            r_vclk <= 1'b0;
            r_de   <= 1'b0;
            r_fs   <= 1'b0;
        end else begin
            r_fs <= w_tick && (w_h_next == '0) && (w_v_next == '0);
            if (enable) begin
                r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
                r_vclk <= (32'(r_div) < DIV_HALF);
            end
            if (w_tick) begin
                r_de <= w_h_nact && w_v_nact;
            end
        end
    end

    assign vCLK        = r_vclk;
    assign De          = r_de;
    assign frame_start = r_fs;

`ifdef VTG_TESTPAT_EN
    localparam int unsigned BAR_W = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;

    logic [2:0]        w_bar;
    logic [DATA_W-1:0] r_pix;

    always_comb begin
        w_bar = 3'd7;
        if ((32'(w_h_next) / BAR_W) < 7) begin
            w_bar = 3'(32'(w_h_next) / BAR_W);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_pix <= '0;
        end else if (w_tick) begin
            r_pix <= (w_h_nact && w_v_nact) ? DATA_W'(VTG_BARS[w_bar]) : '0;
        end
    end

    assign pix_data = r_pix;
`else
    assign pix_data = '0;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a 16x8 raster: directed scenarios then random
// enable/restart/reset traffic, checked against a linear pixel-index model.
module tb_vid_timing_gen;

    localparam int HT    = 16;
    localparam int VT    = 8;
    localparam int FRAME = HT * VT;
    localparam int DIV   = 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic        enable;
    logic        sync_restart;
    logic        vCLK;
    logic        Hs;
    logic        Vs;
    logic        De;
    logic [3:0]  pix_x;
    logic [2:0]  pix_y;
    logic        frame_start;
    logic [15:0] pix_data;

    vid_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(DIV), .DATA_W(16)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .enable       (enable),
        .sync_restart (sync_restart),
        .vCLK         (vCLK),
        .Hs           (Hs),
        .Vs           (Vs),
        .De           (De),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_start  (frame_start),
        .pix_data     (pix_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pos;
    int en_cnt;
    int cyc = 0;
    int last_fs = -1;
    bit period_on = 1'b0;
    logic exp_vclk;
    logic exp_fs;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk: apply inputs, advance the model at the edge, then compare all outputs.
    task automatic cycle(input logic e, input logic sr, input logic rst);
        int x;
        int y;
        logic de;
        logic [15:0] pd;
        enable = e; sync_restart = sr; Reset = rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pos = FRAME - 1; en_cnt = 0; exp_vclk = 1'b0; exp_fs = 1'b0;
        end else if (e) begin
            exp_vclk = ((en_cnt % DIV) < DIV / 2);
            en_cnt++;
            exp_fs = 1'b0;
            if (en_cnt % DIV == 0) begin
                pos = sr ? 0 : (pos + 1) % FRAME;
                exp_fs = (pos == 0);
            end
        end else begin
            exp_fs = 1'b0;
        end
        #1;
        x  = pos % HT;
        y  = pos / HT;
        de = (x < 8) && (y < 4);
        pd = 16'h0;
`ifdef VTG_TESTPAT_EN
        if (de) pd = bars[x];
`endif
        chk("pix_x", 32'(pix_x), 32'(x));
        chk("pix_y", 32'(pix_y), 32'(y));
        chk("De", 32'(De), 32'(de));
        chk("Hs", 32'(Hs), 32'(!(x >= 10 && x < 12)));
        chk("Vs", 32'(Vs), 32'(!(y == 5)));
        chk("vCLK", 32'(vCLK), 32'(exp_vclk));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        chk("pix_data", 32'(pix_data), 32'(pd));
        if (frame_start === 1'b1) begin
            if (period_on && last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'd256);
            last_fs = cyc;
        end
    endtask

    initial begin
        int prev_fs;
        int n_fs;

        // Reset state
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        chk("rst_pix_x", 32'(pix_x), 32'd15);
        chk("rst_pix_y", 32'(pix_y), 32'd7);

        // Release: wrap to (0,0) with frame_start on the 2nd clk
        cycle(1'b1, 1'b0, 1'b0);
        chk("fs_1st_clk", 32'(frame_start), 32'd0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("fs_2nd_clk", 32'(frame_start), 32'd1);
        chk("de_origin", 32'(De), 32'd1);

        // Free run over two-plus frames
        period_on = 1'b1;
        repeat (600) cycle(1'b1, 1'b0, 1'b0);
        period_on = 1'b0;

        // Freeze for 10 clk at pix_x=5: next frame_start arrives 10 clk late
        for (int i = 0; i < 64 && (pos % HT) != 5; i++) cycle(1'b1, 1'b0, 1'b0);
        prev_fs = last_fs;
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400 && last_fs == prev_fs; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("fs_late", 32'(last_fs - prev_fs), 32'd266);

        // Genlock at (5,2)
        for (int i = 0; i < 600 && pos != 2 * HT + 5; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("restart_fs", 32'(frame_start), 32'd1);

        // Genlock coinciding with the natural frame wrap: exactly one pulse
        for (int i = 0; i < 600 && pos != FRAME - 1; i++) cycle(1'b1, 1'b0, 1'b0);
        n_fs = 0;
        cycle(1'b1, 1'b1, 1'b0); n_fs += int'(frame_start);
        cycle(1'b1, 1'b1, 1'b0); n_fs += int'(frame_start);
        repeat (3) begin cycle(1'b1, 1'b0, 1'b0); n_fs += int'(frame_start); end
        chk("wrap_restart_once", 32'(n_fs), 32'd1);

        // Reset at (9,3) outranks enable and sync_restart
        for (int i = 0; i < 600 && pos != 3 * HT + 9; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("midrst_hs", 32'(Hs), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("midrst_fs_2nd", 32'(frame_start), 32'd1);

        // Random traffic
        repeat (3000) cycle(($urandom % 10) != 0, ($urandom % 50) == 0, ($urandom % 400) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
